// File: rtl/secded_pkg.sv
// Shared types and constants for the SECDED memory engine.
// Holds FSM states, decode flags and the data-bit placement in the code word.
package secded_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    WR_LO,
    WR_HI,
    DONE
  } state_t;

  localparam logic [1:0] FLG_NONE   = 2'b00;
  localparam logic [1:0] FLG_SINGLE = 2'b01;
  localparam logic [1:0] FLG_DOUBLE = 2'b10;

  // Hamming position of data bit d(j+1), entry j
  localparam logic [10:0][3:0] DATA_POS = {
    4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10,
    4'd9, 4'd7, 4'd6, 4'd5, 4'd3
  };

endpackage

// File: rtl/secded_codec.sv
// Combinational extended-Hamming (16,11) encoder and decoder.
// Encodes raw[10:0]; decodes raw as a code word with single-bit correction.
module secded_codec
  import secded_pkg::*;
(
  input  logic [15:0] raw,
  output logic [15:0] code,
  output logic [10:0] data,
  output logic [1:0]  flags
);

  logic        par;
  logic        par_all;
  logic [3:0]  syn;
  logic [15:0] fixed;

  always_comb begin
    code = '0;
    par  = 1'b0;
    for (int j = 0; j < 11; j++) begin
      code[DATA_POS[j]] = raw[j];
    end
    for (int n = 0; n < 4; n++) begin
      par = 1'b0;
      for (int k = 1; k < 16; k++) begin
        if (k[n]) par ^= code[k];
      end
      code[1 << n] = par;
    end
    code[0] = ^code[15:1];
  end

  always_comb begin
    syn     = '0;
    par_all = ^raw;
    fixed   = raw;
    data    = '0;
    for (int k = 1; k < 16; k++) begin
      if (raw[k]) syn ^= k[3:0];
    end
    // syndrome 0 with odd parity points at p0 itself
    if (par_all) fixed[syn] = ~fixed[syn];
    if (par_all) flags = FLG_SINGLE;
    else if (syn != '0) flags = FLG_DOUBLE;
    else flags = FLG_NONE;
    for (int j = 0; j < 11; j++) begin
      data[j] = fixed[DATA_POS[j]];
    end
  end

endmodule

// File: rtl/secded_mem_engine.sv
// Memory-to-memory SECDED engine: encodes or decodes NUM_MSG 16-bit words.
// Four cycles per message: read low, read high, write low, write high.
module secded_mem_engine
  import secded_pkg::*;
#(
  parameter int NUM_MSG      = 15,
  parameter int AW           = 8,
  parameter int ENC_SRC_BASE = 0,
  parameter int ENC_DST_BASE = 30,
  parameter int DEC_SRC_BASE = 30,
  parameter int DEC_DST_BASE = 0,
  localparam int CW = $clog2(NUM_MSG + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req,
  input  logic          mode,
  output logic          ack,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rd_data,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wr_data,
  output logic [CW-1:0] n_single,
  output logic [CW-1:0] n_double
);

  localparam int IW = 7;
  localparam logic [AW-1:0] ENC_SRC = AW'(ENC_SRC_BASE);
  localparam logic [AW-1:0] ENC_DST = AW'(ENC_DST_BASE);
  localparam logic [AW-1:0] DEC_SRC = AW'(DEC_SRC_BASE);
  localparam logic [AW-1:0] DEC_DST = AW'(DEC_DST_BASE);
  localparam logic [IW-1:0] LAST    = IW'(NUM_MSG - 1);

  state_t        state;
  logic [IW-1:0] idx;
  logic          mode_q;
  logic [7:0]    lo_q;
  logic [7:0]    hi_q;

  logic [15:0]   raw;
  logic [15:0]   code;
  logic [10:0]   data;
  logic [1:0]    flags;
  logic [7:0]    res_lo;
  logic [7:0]    res_hi;
  logic [AW-1:0] src;
  logic [AW-1:0] dst;

  function automatic logic [AW-1:0] addr_of(
    input logic [AW-1:0] base,
    input logic [IW-1:0] i,
    input logic          odd
  );
    return base + AW'({i, odd});
  endfunction

  // high byte is still on the bus while in RD_HI
  assign raw = (state == RD_HI) ? {mem_rd_data, lo_q}
                                : {hi_q, lo_q};
  assign src = mode_q ? DEC_SRC : ENC_SRC;
  assign dst = mode_q ? DEC_DST : ENC_DST;

  assign res_lo = mode_q ? data[7:0] : code[7:0];
  assign res_hi = mode_q ? {flags, 3'b000, data[10:8]}
                         : code[15:8];

  secded_codec u_codec (
    .raw   (raw),
    .code  (code),
    .data  (data),
    .flags (flags)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      mode_q      <= 1'b0;
      lo_q        <= '0;
      hi_q        <= '0;
      ack         <= 1'b0;
      mem_addr    <= '0;
      mem_wr_en   <= 1'b0;
      mem_wr_data <= '0;
      n_single    <= '0;
      n_double    <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (req) begin
            mode_q   <= mode;
            idx      <= '0;
            n_single <= '0;
            n_double <= '0;
            ack      <= 1'b0;
            mem_addr <= mode ? DEC_SRC : ENC_SRC;
            state    <= RD_LO;
          end
        end
        RD_LO: begin
          lo_q     <= mem_rd_data;
          mem_addr <= addr_of(src, idx, 1'b1);
          state    <= RD_HI;
        end
        RD_HI: begin
          hi_q        <= mem_rd_data;
          mem_addr    <= addr_of(dst, idx, 1'b0);
          mem_wr_en   <= 1'b1;
          mem_wr_data <= res_lo;
          state       <= WR_LO;
        end
        WR_LO: begin
          mem_addr    <= addr_of(dst, idx, 1'b1);
          mem_wr_data <= res_hi;
          state       <= WR_HI;
        end
        WR_HI: begin
          if (mode_q && flags == FLG_SINGLE)
            n_single <= n_single + 1'b1;
          if (mode_q && flags == FLG_DOUBLE)
            n_double <= n_double + 1'b1;
          mem_wr_en   <= 1'b0;
          mem_wr_data <= '0;
          if (idx == LAST) begin
            ack      <= 1'b1;
            mem_addr <= '0;
            state    <= DONE;
          end else begin
            idx      <= idx + 1'b1;
            mem_addr <= addr_of(src, idx + 1'b1, 1'b0);
            state    <= RD_LO;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/secded_mem_engine.md
SECDED_MEM_ENGINE -- requirements
Module: secded_mem_engine

Interface
REQ-001 Parameter NUM_MSG, default 15, number of messages processed per request (1..127).
REQ-002 Parameter AW, default 8, data-memory byte-address width.
REQ-003 Parameters ENC_SRC_BASE=0, ENC_DST_BASE=30, DEC_SRC_BASE=30, DEC_DST_BASE=0: byte base addresses per mode.
REQ-004 Ports SHALL be:
 clock  in  1  sole clock, rising edge
 reset  in  1  asynchronous, active-high reset
 req  in  1  start request, sampled on rising edge
 mode  in  1  0 = encode, 1 = decode; sampled with accepted req
 ack  out  1  done, registered level
 mem_addr  out  AW  byte address to data memory
 mem_rd_data  in  8  data-memory byte, combinational read of mem_addr
 mem_wr_en  out  1  write strobe, memory writes on rising edge
 mem_wr_data  out  8  write byte
 n_single  out  $clog2(NUM_MSG+1)  count of single-error messages (decode)
 n_double  out  $clog2(NUM_MSG+1)  count of double-error messages (decode)

Function
REQ-005 FSM states SHALL be IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE; message index i from 0 to NUM_MSG-1.
REQ-006 req high at an edge in IDLE or DONE SHALL latch mode, clear i, n_single and n_double, drop ack, and go to RD_LO; req in any other state is ignored.
REQ-007 RD_LO SHALL address SRC+2i and capture the low byte; RD_HI SHALL address SRC+2i+1 and capture the high byte.
REQ-008 WR_LO SHALL write result low byte to DST+2i; WR_HI SHALL write high byte to DST+2i+1, then go to RD_LO with i+1, or to DONE when i=NUM_MSG-1.
REQ-009 Each message SHALL take exactly 4 cycles; ack SHALL be high from the edge 4*NUM_MSG cycles after the accepting edge (60 for default) and held until the next accepted req or reset.
REQ-010 mem_wr_en SHALL be high only in WR_LO/WR_HI; mem_addr and mem_wr_data SHALL be 0 in IDLE and DONE.
REQ-011 Encode: 11-bit data d[11:1] = {hi[2:0], lo[7:0]}; hi[7:3] ignored.
REQ-012 Encode output word SHALL be {d11..d5, p8, d4..d2, p4, d1, p2, p1, p0}, with bit k (1..15) the Hamming position and bit 0 = p0.
REQ-013 pN SHALL be even parity over the positions k>0 with bit N of k set; p0 SHALL be XOR of all other 15 bits.
REQ-014 Decode: syndrome s = XOR of indices k (1..15) of set bits; P = XOR of all 16 bits.
REQ-015 Decode s=0, P=0: flags 00, data unchanged.
REQ-016 Decode P=1: single error at position s (s=0 means p0), bit corrected, flags 01, n_single+1.
REQ-017 Decode s!=0, P=0: double error, flags 10, data extracted uncorrected, n_double+1.
REQ-018 Decode output SHALL be lo = d[8:1], hi = {F1, F0, 3'b000, d[11:9]}.
REQ-019 Counters SHALL update at the WR_HI edge and SHALL remain 0 in encode mode.

Reset
REQ-020 Reset SHALL force IDLE, i=0, ack=0, mem_wr_en=0, n_single=n_double=0, with no further writes.
REQ-021 Reset mid-operation SHALL abandon the run; already-written memory bytes remain, and the next req restarts from message 0.

Structure
REQ-022 Package secded_pkg SHALL hold the state enum, flag constants (FLG_NONE=2'b00, FLG_SINGLE=2'b01, FLG_DOUBLE=2'b10) and the encode bit-position mapping.
REQ-023 Encode, syndrome and correction logic SHALL live in one combinational sub-module secded_codec (16-bit in, 11-bit data/16-bit code out, flags out), instantiated once.

Verification
REQ-024 Encode: d=0x001 -> dst bytes lo=0x0F, hi=0x00; d=0x7FF -> lo=0xFF, hi=0xFF; d=0x000 -> 0x00/0x00.
REQ-025 Encode 15 random messages (NUM_MSG=15) -> bytes 30..59 match a reference model; ack rises 60 cycles after accept.
REQ-026 Decode 0x002F -> lo=0x01, hi=0x40, n_single=1; decode 0x000E (p0 flipped) -> lo=0x01, hi=0x40.
REQ-027 Decode 0x003F -> lo=0x03, hi=0x80, n_double=1; decode 0x000F -> lo=0x01, hi=0x00.
REQ-028 Assert reset at message 5 -> ack stays 0, bytes for messages 5.. are untouched, outputs reset; a new req completes normally.
REQ-029 req pulse while busy -> ignored, same ack timing; req in DONE -> ack drops the next cycle and the run restarts.
